mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/mc_wait_cnt.sv | 36 +++
 rtl/mc_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller (mc_ctrl and mc_wait_cnt).
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_RTEX   = 4'd6,
    ST_RTWB   = 4'd7,
    ST_BEQEX  = 4'd8,
    ST_JEX    = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_EXC    = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] ALUB_REG    = 2'd0;
  localparam logic [1:0] ALUB_FOUR   = 2'd1;
  localparam logic [1:0] ALUB_IMM    = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH = 2'd3;

  typedef struct packed {
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       timeout;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_mem_wait(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_cnt.sv
// Saturating memory-wait counter; expired flags the abort point (MEM_TIMEOUT=0 disables it).
module mc_wait_cnt #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-style control FSM with memory-wait timeout.
// Define MC_CTRL_ILLEGAL_TRAP_EN to route unknown opcodes through the TRAP state.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [3:0] state,
  output logic       timeout,
  output logic       illegal
);

  state_e state_q, state_d;
  logic   run_q, run_d;
  logic   waiting, expired, tmo;
  ctrl_t  ctrl;

  // funct is consumed by the ALU control, not by this FSM.
  logic unused_funct;
  assign unused_funct = ^funct;

  // run_q keeps outputs at zero until the first clock after reset release.
  assign waiting = run_q && is_mem_wait(state_q) && !mem_ready;
  assign tmo     = waiting && expired;

  mc_wait_cnt #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (!waiting || tmo),
    .inc    (waiting),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    if (!run_q) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (mem_ready)  state_d = ST_DECODE;
          else if (tmo)   state_d = ST_FETCH;
        end
        ST_DECODE: begin
          case (opcode)
            OP_RTYPE:     state_d = ST_RTEX;
            OP_LW, OP_SW: state_d = ST_MEMADR;
            OP_BEQ:       state_d = ST_BEQEX;
            OP_J:         state_d = ST_JEX;
            OP_ADDI:      state_d = ST_ADDIEX;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            default:      state_d = ST_TRAP;
`else
            default:      state_d = ST_FETCH;
`endif
          endcase
        end
        ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
        ST_MEMRD: begin
          if (mem_ready)  state_d = ST_MEMWB;
          else if (tmo)   state_d = ST_FETCH;
        end
        ST_MEMWR: begin
          if (mem_ready || tmo) state_d = ST_FETCH;
        end
        ST_RTEX:   state_d = ST_RTWB;
        ST_ADDIEX: state_d = ST_ADDIWB;
        default:   state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    ctrl = '0;
    if (run_q) begin
      case (state_q)
        ST_FETCH: begin
          ctrl.memread = 1'b1;
          ctrl.alusrcb = ALUB_FOUR;
          ctrl.aluop   = ALUOP_ADD;
          ctrl.pcsrc   = PCSRC_ALU;
          ctrl.irwrite = mem_ready;
          ctrl.pcwrite = mem_ready;
        end
        ST_DECODE: begin
          ctrl.alusrcb = ALUB_IMM_SH;
          ctrl.aluop   = ALUOP_ADD;
        end
        ST_MEMADR, ST_ADDIEX: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = ALUB_IMM;
          ctrl.aluop   = ALUOP_ADD;
        end
        ST_MEMRD: begin
          ctrl.iord    = 1'b1;
          ctrl.memread = 1'b1;
        end
        ST_MEMWB: begin
          ctrl.memtoreg = 1'b1;
          ctrl.regwrite = 1'b1;
        end
        ST_MEMWR: begin
          ctrl.iord     = 1'b1;
          ctrl.memwrite = 1'b1;
        end
        ST_RTEX: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = ALUB_REG;
          ctrl.aluop   = ALUOP_FUNCT;
        end
        ST_RTWB: begin
          ctrl.regdst   = 1'b1;
          ctrl.regwrite = 1'b1;
        end
        ST_BEQEX: begin
          ctrl.alusrca = 1'b1;
          ctrl.alusrcb = ALUB_REG;
          ctrl.aluop   = ALUOP_SUB;
          ctrl.pcsrc   = PCSRC_ALUOUT;
          ctrl.pcwrite = zero;
        end
        ST_JEX: begin
          ctrl.pcsrc   = PCSRC_JUMP;
          ctrl.pcwrite = 1'b1;
        end
        ST_ADDIWB: begin
          ctrl.regwrite = 1'b1;
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ST_TRAP: begin
          ctrl.illegal = 1'b1;
          ctrl.pcsrc   = PCSRC_EXC;
          ctrl.pcwrite = 1'b1;
        end
`endif
        default: ;
      endcase
    end
    ctrl.timeout = tmo;
  end

  assign pcwrite  = ctrl.pcwrite;
  assign pcsrc    = ctrl.pcsrc;
  assign iord     = ctrl.iord;
  assign memread  = ctrl.memread;
  assign memwrite = ctrl.memwrite;
  assign irwrite  = ctrl.irwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign timeout  = ctrl.timeout;
  assign illegal  = ctrl.illegal;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus queues per-cycle expected control vectors, a monitor compares them.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic       timeout, illegal;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic [3:0] state;
  logic [20:0] got;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [20:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  mc_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcwrite(pcwrite), .pcsrc(pcsrc), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .state(state), .timeout(timeout), .illegal(illegal)
  );

  assign got = {state, pcwrite, pcsrc, iord, memread, memwrite, irwrite,
                regdst, memtoreg, regwrite, alusrca, alusrcb, aluop, timeout, illegal};

  function automatic logic [20:0] mk(input int st, input int pcw, input int pcs,
                                     input int io, input int mr, input int mw, input int irw,
                                     input int rd, input int mtr, input int rw, input int asa,
                                     input int asb, input int aop, input int to, input int ill);
    return {4'(st), 1'(pcw), 2'(pcs), 1'(io), 1'(mr), 1'(mw), 1'(irw),
            1'(rd), 1'(mtr), 1'(rw), 1'(asa), 2'(asb), 2'(aop), 1'(to), 1'(ill)};
  endfunction

  //                             st pcw pcs io mr mw irw rd mtr rw asa asb aop to ill
  localparam logic [20:0] RST    = mk(0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
  localparam logic [20:0] F_WAIT = mk(0,  0, 0, 0, 1, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0);
  localparam logic [20:0] F_GO   = mk(0,  1, 0, 0, 1, 0, 1,  0, 0, 0, 0,  1, 0, 0, 0);
  localparam logic [20:0] DEC    = mk(1,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  3, 0, 0, 0);
  localparam logic [20:0] MADR   = mk(2,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  2, 0, 0, 0);
  localparam logic [20:0] MRD    = mk(3,  0, 0, 1, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
  localparam logic [20:0] MRD_TO = mk(3,  0, 0, 1, 1, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0);
  localparam logic [20:0] MWB    = mk(4,  0, 0, 0, 0, 0, 0,  0, 1, 1, 0,  0, 0, 0, 0);
  localparam logic [20:0] MWR    = mk(5,  0, 0, 1, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0);
  localparam logic [20:0] RTEX   = mk(6,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 2, 0, 0);
  localparam logic [20:0] RTWB   = mk(7,  0, 0, 0, 0, 0, 0,  1, 0, 1, 0,  0, 0, 0, 0);
  localparam logic [20:0] BEQ_N  = mk(8,  0, 1, 0, 0, 0, 0,  0, 0, 0, 1,  0, 1, 0, 0);
  localparam logic [20:0] BEQ_T  = mk(8,  1, 1, 0, 0, 0, 0,  0, 0, 0, 1,  0, 1, 0, 0);
  localparam logic [20:0] JEX    = mk(9,  1, 2, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
  localparam logic [20:0] AEX    = mk(10, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  2, 0, 0, 0);
  localparam logic [20:0] AWB    = mk(11, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  0, 0, 0, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam logic [20:0] TRAP   = mk(12, 1, 3, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1);
`endif

  // Drive one cycle's inputs just after the edge and queue what that cycle must show.
  task automatic step(input int rn, input int opc, input int rdy, input int z,
                      input logic [20:0] e, input string tag);
    @(posedge clk);
    #1;
    reset_n   = 1'(rn);
    opcode    = 6'(opc);
    mem_ready = 1'(rdy);
    zero      = 1'(z);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [20:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s got=%06h exp=%06h (state got %0d exp %0d)", t, got, e, got[20:17], e[20:17]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    step(0, 'h00, 1, 0, RST, "rst0");
    step(0, 'h00, 1, 0, RST, "rst1");
    step(1, 'h23, 1, 0, RST, "release");
    // lw with memory always ready
    step(1, 'h23, 1, 0, F_GO, "lw_fetch");
    step(1, 'h23, 1, 0, DEC,  "lw_dec");
    step(1, 'h23, 1, 0, MADR, "lw_adr");
    step(1, 'h23, 1, 0, MRD,  "lw_rd");
    step(1, 'h23, 1, 0, MWB,  "lw_wb");
    // beq not taken, then taken
    step(1, 'h04, 1, 0, F_GO,  "beq_fetch");
    step(1, 'h04, 1, 0, DEC,   "beq_dec");
    step(1, 'h04, 1, 0, BEQ_N, "beq_nt");
    step(1, 'h04, 1, 1, F_GO,  "beq2_fetch");
    step(1, 'h04, 1, 1, DEC,   "beq2_dec");
    step(1, 'h04, 1, 1, BEQ_T, "beq_t");
    // sw with three wait cycles, below the timeout
    step(1, 'h2B, 1, 0, F_GO, "sw_fetch");
    step(1, 'h2B, 1, 0, DEC,  "sw_dec");
    step(1, 'h2B, 1, 0, MADR, "sw_adr");
    for (int i = 0; i < 3; i++) step(1, 'h2B, 0, 0, MWR, "sw_wait");
    step(1, 'h2B, 1, 0, MWR,  "sw_done");
    // R-type, addi, j
    step(1, 'h00, 1, 0, F_GO, "rt_fetch");
    step(1, 'h00, 1, 0, DEC,  "rt_dec");
    step(1, 'h00, 1, 0, RTEX, "rt_ex");
    step(1, 'h00, 1, 0, RTWB, "rt_wb");
    step(1, 'h08, 1, 0, F_GO, "addi_fetch");
    step(1, 'h08, 1, 0, DEC,  "addi_dec");
    step(1, 'h08, 1, 0, AEX,  "addi_ex");
    step(1, 'h08, 1, 0, AWB,  "addi_wb");
    step(1, 'h02, 1, 0, F_GO, "j_fetch");
    step(1, 'h02, 1, 0, DEC,  "j_dec");
    step(1, 'h02, 1, 0, JEX,  "j_ex");
    // lw stalled until the timeout fires
    step(1, 'h23, 1, 0, F_GO, "lwto_fetch");
    step(1, 'h23, 1, 0, DEC,  "lwto_dec");
    step(1, 'h23, 1, 0, MADR, "lwto_adr");
    for (int i = 0; i < 4; i++) step(1, 'h23, 0, 0, MRD, "lwto_wait");
    step(1, 'h23, 0, 0, MRD_TO, "lwto_pulse");
    step(1, 'h23, 0, 0, F_WAIT, "lwto_refetch");
    // mem_ready arriving on the would-be timeout cycle wins
    step(1, 'h23, 1, 0, F_GO, "race_fetch");
    step(1, 'h23, 1, 0, DEC,  "race_dec");
    step(1, 'h23, 1, 0, MADR, "race_adr");
    for (int i = 0; i < 4; i++) step(1, 'h23, 0, 0, MRD, "race_wait");
    step(1, 'h23, 1, 0, MRD,  "race_rd");
    step(1, 'h23, 1, 0, MWB,  "race_wb");
    // unknown opcode
    step(1, 'h3F, 1, 0, F_GO, "ill_fetch");
    step(1, 'h3F, 1, 0, DEC,  "ill_dec");
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    step(1, 'h3F, 1, 0, TRAP, "ill_trap");
`endif
    step(1, 'h00, 1, 0, F_GO, "ill_ret");
    // reset asserted right as RTEX is entered
    step(1, 'h00, 1, 0, DEC,  "rst_dec");
    step(0, 'h00, 1, 0, RST,  "rst_rtex");
    step(0, 'h00, 1, 0, RST,  "rst_hold");
    step(1, 'h00, 1, 0, RST,  "release2");
    step(1, 'h00, 1, 0, F_GO, "post_fetch");
    step(1, 'h00, 1, 0, DEC,  "post_dec");
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
